// File: rtl/uart_pkg.sv
// Types and widths shared by the UART transmitter, receiver and parity checker.
package uart_pkg;

  localparam int UART_DATA_W  = 8;
  localparam int UART_FRAME_W = 9;
  localparam int PARITY_IDX   = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } uart_state_t;

endpackage

// File: rtl/uart_rx_deserializer_if.sv
// Serial line and received-frame signals of the UART receive front end.
interface uart_rx_deserializer_if;
  import uart_pkg::*;

  logic                    rx_in;
  logic [UART_FRAME_W-1:0] frame_out;
  logic                    frame_valid;
  logic                    framing_error;
  logic                    busy;

  // The deserializer sources frames; the far side drives the line and consumes frames.
  modport master (
    input  rx_in,
    output frame_out, frame_valid, framing_error, busy
  );

  modport slave (
    output rx_in,
    input  frame_out, frame_valid, framing_error, busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable reset value.
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so both flops sample pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: frames start, 8 data bits LSB-first, parity and stop into a 9-bit word.
module uart_rx_deserializer
   import uart_pkg::*;
#(
   parameter  int CLKS_PER_BIT = 16,
   localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   uart_rx_deserializer_if.master bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_W - 1);

   uart_state_t             state;
   logic [CNT_W-1:0]        clk_cnt;
   logic [2:0]              bit_idx;
   logic [UART_DATA_W-1:0]  shift_reg;
   logic                    parity_bit;
   logic                    rx_s;
   logic                    bit_end;
   logic [UART_FRAME_W-1:0] good_frame;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.rx_in),
      .q     (rx_s)
   );

   assign bit_end = (clk_cnt == CNT_LAST);

   always_comb begin
      good_frame                  = '0;
      good_frame[PARITY_IDX]      = parity_bit;
      good_frame[UART_DATA_W-1:0] = shift_reg;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         clk_cnt           <= '0;
         bit_idx           <= '0;
         shift_reg         <= '0;
         parity_bit        <= 1'b0;
         bus.frame_out     <= '0;
         bus.frame_valid   <= 1'b0;
         bus.framing_error <= 1'b0;
         bus.busy          <= 1'b0;
      end else begin
         // NOTE: strobes default low every cycle so each assertion below is a single-cycle pulse.
         bus.frame_valid   <= 1'b0;
         bus.framing_error <= 1'b0;

         unique case (state)
            IDLE: begin
               clk_cnt <= '0;
               bit_idx <= '0;
               if (!rx_s) begin
                  state    <= START;
                  bus.busy <= 1'b1;
               end
            end

            // Re-check at mid start bit so short glitches are rejected.
            START: begin
               if (clk_cnt == CNT_MID) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            DATA: begin
               if (bit_end) begin
                  clk_cnt            <= '0;
                  shift_reg[bit_idx] <= rx_s;
                  bit_idx            <= bit_idx + 1'b1;
                  if (bit_idx == IDX_LAST) state <= PARITY;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            PARITY: begin
               if (bit_end) begin
                  clk_cnt    <= '0;
                  parity_bit <= rx_s;
                  state      <= STOP;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (rx_s) begin
                     bus.frame_out   <= good_frame;
                     bus.frame_valid <= 1'b1;
                     bus.busy        <= 1'b0;
                     state           <= IDLE;
                  end else begin
                     bus.framing_error <= 1'b1;
                     state             <= BREAK_WAIT;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end

            // A held-low line must return high before another start bit is accepted.
            BREAK_WAIT: begin
               if (rx_s) begin
                  bus.busy <= 1'b0;
                  state    <= IDLE;
               end
            end

            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: directed and random serial frames compared against a line-level receiver model.
module tb_uart_rx_deserializer;

   localparam int BIT = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_rx_deserializer_if bus ();

   uart_rx_deserializer #(.CLKS_PER_BIT(BIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Observed strobes, captured on the falling edge.
   logic [8:0] got_q[$];
   int         stamp_q[$];
   int         err_seen  = 0;
   int         both_seen = 0;

   // Reference model state, derived from the transmitted line image.
   logic [8:0] exp_q[$];
   int         exp_err   = 0;
   logic [8:0] last_good = 9'h000;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (bus.frame_valid) begin
         got_q.push_back(bus.frame_out);
         stamp_q.push_back(cyc);
      end
      if (bus.framing_error) err_seen++;
      if (bus.frame_valid && bus.framing_error) both_seen++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      bus.rx_in = b;
      idle(BIT);
   endtask

   // Drives an 11-bit line image (bit 0 = start) and predicts what an ideal receiver reports.
   task automatic run_frame(input logic [7:0] d, input logic p, input logic s);
      logic [10:0] img;
      img = {s, p, d, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(img[i]);
      if (img[10]) begin
         last_good = {img[9], img[8:1]};
         exp_q.push_back(last_good);
      end else begin
         exp_err++;
      end
   endtask

   task automatic verify(input string tag);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      while (got_q.size() > 0 && exp_q.size() > 0)
         check({tag, "_frame"}, got_q.pop_front(), exp_q.pop_front());
      got_q.delete();
      exp_q.delete();
      stamp_q.delete();
      check({tag, "_ferr"}, err_seen, exp_err);
      check({tag, "_both"}, both_seen, 0);
      check({tag, "_hold"}, bus.frame_out, last_good);
      check({tag, "_busy"}, bus.busy, 1'b0);
   endtask

   initial begin
      int n;
      int sz;
      logic [7:0] d;
      logic       p;
      logic       s;

      bus.rx_in = 1'b1;
      rst_n     = 1'b0;
      idle(3);
      rst_n = 1'b1;
      idle(2);
      check("rst_frame", bus.frame_out, 9'h000);
      check("rst_valid", bus.frame_valid, 1'b0);
      check("rst_ferr", bus.framing_error, 1'b0);
      check("rst_busy", bus.busy, 1'b0);

      // 1: plain frame
      run_frame(8'hA5, 1'b0, 1'b1);
      idle(20);
      verify("t1");

      // 2: parity bit set; the 9-bit word is even overall
      run_frame(8'h01, 1'b1, 1'b1);
      idle(20);
      verify("t2");
      check("t2_even_parity", ^bus.frame_out, 1'b0);

      // 3: 5-clk glitch from idle
      bus.rx_in = 1'b0;
      idle(5);
      check("t3_busy_during", bus.busy, 1'b1);
      bus.rx_in = 1'b1;
      idle(10);
      verify("t3");

      // 4: bad stop, then a held break
      run_frame(8'h3C, 1'b0, 1'b0);
      idle(40);
      check("t4_busy_in_break", bus.busy, 1'b1);
      bus.rx_in = 1'b1;
      n = 0;
      while (bus.busy && n < 20) begin
         idle(1);
         n++;
      end
      check("t4_busy_fall_2to3", (n >= 2 && n <= 3), 1'b1);
      idle(200);
      verify("t4");

      // 5: back-to-back frames with no idle gap
      sz = stamp_q.size();
      run_frame(8'h55, 1'b0, 1'b1);
      run_frame(8'hFF, 1'b0, 1'b1);
      idle(20);
      n = (stamp_q.size() == sz + 2) ? stamp_q[sz+1] - stamp_q[sz] : -1;
      check("t5_spacing", (n >= 11*BIT - 1 && n <= 11*BIT + 1), 1'b1);
      verify("t5");

      // 6: reset during data bit 4 of 0x81
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      bus.rx_in = 1'b0;
      idle(8);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check("t6_rst_frame", bus.frame_out, 9'h000);
      check("t6_rst_valid", bus.frame_valid, 1'b0);
      check("t6_rst_ferr", bus.framing_error, 1'b0);
      check("t6_rst_busy", bus.busy, 1'b0);
      last_good = 9'h000;
      bus.rx_in = 1'b1;
      idle(200);
      verify("t6_abandon");
      run_frame(8'h81, 1'b0, 1'b1);
      idle(20);
      verify("t6_clean");

      // Random frames, roughly a quarter with a bad stop bit
      for (int k = 0; k < 10; k++) begin
         d = 8'($urandom);
         p = 1'($urandom);
         s = ($urandom_range(3) != 0);
         run_frame(d, p, s);
         bus.rx_in = 1'b1;
         idle(40);
         verify("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
